// File: rtl/vend_credit_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vend_credit_ctrl                                              |
// | Purpose  : Credit accumulator and vend/change controller downstream of   |
// |            the coin acceptor. Coins add to a saturating credit register, |
// |            an affordable purchase request produces a one-cycle vend      |
// |            strobe, and leftover credit is paid back as timed hopper      |
// |            pulses (one credit unit per pulse) after a vend or on refund. |
// | Ports    : clk          - system clock                                   |
// |            rst          - asynchronous reset, active low                 |
// |            coin_in      - coin value from acceptor, 0 = no coin          |
// |            vend_req     - purchase request level                         |
// |            refund_req   - refund request level                           |
// |            credit       - current credit                                 |
// |            vend         - one-cycle vend strobe                          |
// |            change_pulse - hopper drive, one pulse per unit returned      |
// |            busy         - high whenever the controller is not idle       |
// |            overflow     - sticky, a coin add saturated the credit        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vend_credit_ctrl #(
  parameter int PRICE              = 10,
  parameter int CREDIT_W           = 8,
  parameter int CHANGE_HIGH_CYCLES = 2500,
  parameter int CHANGE_LOW_CYCLES  = 2500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          coin_in,
  input  logic                vend_req,
  input  logic                refund_req,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                change_pulse,
  output logic                busy,
  output logic                overflow
);

  // Arithmetic is done wide enough for both the credit and the 6-bit coin,
  // plus one carry bit so saturation can be detected.
  localparam int C_SUM_W   = ((CREDIT_W > 6) ? CREDIT_W : 6) + 1;
  localparam int C_MAX_CYC = (CHANGE_HIGH_CYCLES > CHANGE_LOW_CYCLES) ?
                             CHANGE_HIGH_CYCLES : CHANGE_LOW_CYCLES;
  // Timer counts N-1 down to 0, so $clog2(N) bits are enough.
  localparam int C_TIMER_W = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;

  localparam logic [C_SUM_W-1:0]   C_CREDIT_MAX = {{(C_SUM_W-CREDIT_W){1'b0}}, {CREDIT_W{1'b1}}};
  localparam logic [C_SUM_W-1:0]   C_PRICE_S    = C_SUM_W'(PRICE);
  localparam logic [CREDIT_W-1:0]  C_PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [C_SUM_W-1:0]   C_ONE_S      = C_SUM_W'(1);
  localparam logic [C_TIMER_W-1:0] C_HIGH_LOAD  = C_TIMER_W'(CHANGE_HIGH_CYCLES - 1);
  localparam logic [C_TIMER_W-1:0] C_LOW_LOAD   = C_TIMER_W'(CHANGE_LOW_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VEND   = 2'd1,
    S_CHG_HI = 2'd2,
    S_CHG_LO = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  overflow_q, overflow_d;
  logic [5:0]            coin_prev_q;
  logic                  vend_req_q;
  logic                  refund_req_q;
  logic [C_TIMER_W-1:0]  timer_q, timer_d;
  logic                  vend_strobe_q, vend_strobe_d;
  logic                  change_pulse_q, change_pulse_d;
  logic                  busy_q, busy_d;

  logic                  coin_event;
  logic                  vend_edge;
  logic                  refund_edge;
  logic                  timer_done;
  logic                  vend_take;
  logic [C_SUM_W-1:0]    coin_add;
  logic [C_SUM_W-1:0]    dec;
  logic [C_SUM_W-1:0]    sum;

  always_comb begin
    coin_event  = (coin_in != 6'd0) && (coin_prev_q == 6'd0);
    vend_edge   = vend_req & ~vend_req_q;
    refund_edge = refund_req & ~refund_req_q;
    timer_done  = (timer_q == '0);
    vend_take   = (state_q == S_IDLE) && vend_edge && (credit_q >= C_PRICE_C);

    // Decrement sources are mutually exclusive by state.
    dec = '0;
    if (vend_take) begin
      dec = C_PRICE_S;
    end else if ((state_q == S_CHG_HI) && timer_done) begin
      dec = C_ONE_S;
    end

    coin_add = coin_event ? C_SUM_W'(coin_in) : '0;
    // Cannot underflow: a decrement only happens when credit covers it.
    sum      = C_SUM_W'(credit_q) + coin_add - dec;

    overflow_d = overflow_q;
    if (sum > C_CREDIT_MAX) begin
      credit_d   = {CREDIT_W{1'b1}};
      overflow_d = 1'b1;
    end else begin
      credit_d   = sum[CREDIT_W-1:0];
    end

    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        // A vend edge without enough credit falls through to the refund check.
        if (vend_take) begin
          state_d = S_VEND;
        end else if (refund_edge && (credit_q != '0)) begin
          state_d = S_CHG_HI;
          timer_d = C_HIGH_LOAD;
        end
      end
      S_VEND: begin
        // credit_d includes any coin accepted in this cycle.
        if (credit_d != '0) begin
          state_d = S_CHG_HI;
          timer_d = C_HIGH_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHG_HI: begin
        if (timer_done) begin
          state_d = S_CHG_LO;
          timer_d = C_LOW_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_CHG_LO: begin
        if (timer_done) begin
          if (credit_d != '0) begin
            state_d = S_CHG_HI;
            timer_d = C_HIGH_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // Outputs are registered copies of the next-state decode so they line up
    // with the state they describe.
    vend_strobe_d  = (state_d == S_VEND);
    change_pulse_d = (state_d == S_CHG_HI);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      overflow_q     <= 1'b0;
      coin_prev_q    <= 6'd0;
      vend_req_q     <= 1'b0;
      refund_req_q   <= 1'b0;
      timer_q        <= '0;
      vend_strobe_q  <= 1'b0;
      change_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      overflow_q     <= overflow_d;
      coin_prev_q    <= coin_in;
      vend_req_q     <= vend_req;
      refund_req_q   <= refund_req;
      timer_q        <= timer_d;
      vend_strobe_q  <= vend_strobe_d;
      change_pulse_q <= change_pulse_d;
      busy_q         <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign vend         = vend_strobe_q;
  assign change_pulse = change_pulse_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: doc/vend_credit_ctrl.md
# vend_credit_ctrl

Credit and vend controller directly downstream of the coin acceptor. Takes the acceptor's 6-bit coin value and accumulates it into a saturating credit register. It issues a one-cycle vend strobe when a purchase request is affordable. It pays back remaining credit as timed hopper pulses, one credit unit per pulse, either after a vend or on an explicit refund request.

## Interface
- PRICE, 10: credit units consumed per vend; must satisfy 1 ≤ PRICE ≤ 2^CREDIT_W−1
- CREDIT_W, 8: credit register width
- CHANGE_HIGH_CYCLES, 2500: change_pulse high time in clocks (100 µs @ 25 MHz); ≥1
- CHANGE_LOW_CYCLES, 2500: change_pulse low gap in clocks; ≥1
- clk  input  1  system clock (25 MHz)
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- coin_in  input  6  coin value from coin acceptor; 0 = no coin
- vend_req  input  1  purchase request level, synchronous to clk
- refund_req  input  1  refund request level, synchronous to clk
- credit  output  CREDIT_W  current credit
- vend  output  1  one-cycle vend strobe
- change_pulse  output  1  hopper drive, one pulse per credit unit returned
- busy  output  1  high whenever state ≠ IDLE
- overflow  output  1  sticky; set when a coin add saturated credit

## Operation
- Reset (rst low, async): state IDLE; credit=0, vend=0, change_pulse=0, busy=0, overflow=0; coin_prev, vend_q, refund_q, timer cleared.
- Coin event: coin_in≠0 and coin_prev==0, with coin_prev = registered coin_in. A value held for multiple cycles counts once. Coin events are accepted in every state.
- Credit update per edge: next = credit + coin_add − dec. coin_add is coin_in on a coin event, else 0. dec is PRICE on entry to VEND, 1 at the end of a CHG_HI pulse, else 0. Compute at CREDIT_W+1 bits. If the result exceeds 2^CREDIT_W−1: clamp to max, set overflow. overflow clears only on reset.
- Request edges: vend_edge = vend_req & ~vend_q; refund_edge = refund_req & ~refund_q. Edges are ignored outside IDLE and are not queued.
- States:
  - IDLE: vend_edge and credit ≥ PRICE → VEND (credit −= PRICE on the same edge). Else refund_edge and credit>0 → CHG_HI, timer loaded. Else stay. vend_edge with insufficient credit is ignored; refund_edge then still applies if asserted the same cycle.
  - VEND: vend=1 for exactly this cycle. Next: credit>0 (including coins added this cycle) → CHG_HI, else IDLE.
  - CHG_HI: change_pulse=1; timer counts CHANGE_HIGH_CYCLES. On the last cycle: credit −= 1 (with any concurrent coin add), → CHG_LO.
  - CHG_LO: change_pulse=0 for CHANGE_LOW_CYCLES. Then credit>0 → CHG_HI, else IDLE.
- Coins added during VEND/CHG_* extend the payout; no purchase can occur until back in IDLE.
- Decrement never underflows. CHG_HI is entered only with credit ≥1, and only this block decrements.

## Timing
- vend/vend_req: vend_req first sampled high at edge k (vend_q low) → vend high in cycle k+1 → credit shows the reduced value in that same cycle.
- Coin latency: coin_in first nonzero at edge k → credit updated after edge k.
- change_pulse/credit: change_pulse rises one cycle after VEND, or one cycle after refund_edge. Each pulse is exactly CHANGE_HIGH_CYCLES high, then CHANGE_LOW_CYCLES low. credit decrements at the falling edge of change_pulse.
- Return to IDLE: busy drops after the final CHG_LO gap completes.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset mid-payout: change_pulse and vend drop immediately (async); remaining credit is lost.

## Test plan
Bench parameters: PRICE=10, CHANGE_HIGH_CYCLES=3, CHANGE_LOW_CYCLES=2.

- Coin accumulation: coin_in=5 held 4 cycles, back to 0, then coin_in=7 for 1 cycle → credit 5, then 12. Exactly two adds; vend and change_pulse stay 0.
- Vend with change: credit=12, vend_req high 10 cycles → vend high one cycle with credit=2 in that cycle. Then exactly 2 change_pulse highs of 3 cycles each, separated by 2 low cycles. Final credit=0, busy=0. vend_req still high produces no second vend.
- Insufficient credit: credit=7, vend_req pulse → no vend, credit stays 7. A refund_req pulse then gives 7 change pulses and credit=0.
- Coin during payout: refund at credit=2, coin_in=1 during the first CHG_HI → total 3 change pulses; credit sequence 2→3→2→1→0.
- Saturation: credit=250, coin_in=7 → credit=255, overflow=1. overflow stays 1 after a refund to 0 until rst is asserted.
- Async reset: assert rst low mid CHG_HI → change_pulse, busy, credit, overflow all 0 before the next clock edge. After release, coin_in=3 → credit=3.
